// File: rtl/interrupt_acknowledge_sequencer.sv
// 8259A acknowledge/poll sequencer: tracks INTA pulses and poll reads and emits
// the state and one-cycle strobes used by the interrupt control signal stage.
module interrupt_acknowledge_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       interrupt_acknowledge_n,
    input  logic       read_n,
    input  logic       write_initial_command_word_1,
    input  logic       write_operation_control_word_3,
    input  logic       poll_bit,
    input  logic       u8086_mode,
    input  logic       cascade_slave,
    input  logic       cascade_slave_enable,
    output logic [2:0] control_state,
    output logic [2:0] next_control_state,
    output logic       latch_in_service,
    output logic       end_of_acknowledge_sequence,
    output logic       end_of_poll_command,
    output logic       sequence_abort
);

    typedef enum logic [2:0] {
        CTL_READY = 3'b000,
        ACK1      = 3'b001,
        ACK2      = 3'b010,
        ACK3      = 3'b011,
        POLL      = 3'b100
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    logic [SYNC_STAGES-1:0]   inta_sync_reg;
    logic [SYNC_STAGES-1:0]   read_sync_reg;
    logic                     inta_hist_reg;
    logic                     read_hist_reg;
    logic [2:0]               state_reg;
    logic [2:0]               state_next;
    logic [2:0]               normal_next;
    logic [TIMEOUT_WIDTH-1:0] timeout_count_reg;
    logic                     inta_fall;
    logic                     inta_rise;
    logic                     read_fall;
    logic                     read_rise;
    logic                     slave_ok;
    logic                     timeout_expired;
    logic                     in_ack_state;

    // Synchronizers idle high so a reset never manufactures an edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (reset) begin
                        inta_sync_reg[gi] <= 1'b1;
                        read_sync_reg[gi] <= 1'b1;
                    end else begin
                        inta_sync_reg[gi] <= interrupt_acknowledge_n;
                        read_sync_reg[gi] <= read_n;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clock) begin
                    if (reset) begin
                        inta_sync_reg[gi] <= 1'b1;
                        read_sync_reg[gi] <= 1'b1;
                    end else begin
                        inta_sync_reg[gi] <= inta_sync_reg[gi-1];
                        read_sync_reg[gi] <= read_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            inta_hist_reg <= 1'b1;
            read_hist_reg <= 1'b1;
        end else begin
            inta_hist_reg <= inta_sync_reg[SYNC_STAGES-1];
            read_hist_reg <= read_sync_reg[SYNC_STAGES-1];
        end
    end

    assign inta_fall = inta_hist_reg & ~inta_sync_reg[SYNC_STAGES-1];
    assign inta_rise = ~inta_hist_reg & inta_sync_reg[SYNC_STAGES-1];
    assign read_fall = read_hist_reg & ~read_sync_reg[SYNC_STAGES-1];
    assign read_rise = ~read_hist_reg & read_sync_reg[SYNC_STAGES-1];
    assign slave_ok  = ~cascade_slave | cascade_slave_enable;

    // Protocol transitions only; ICW1 and timeout overrides are layered below.
    always_comb begin
        normal_next = state_reg;
        case (state_reg)
            CTL_READY: begin
                if (write_operation_control_word_3 & poll_bit) normal_next = POLL;
                else if (inta_fall)                            normal_next = ACK1;
            end
            ACK1:    if (inta_rise) normal_next = ACK2;
            ACK2:    if (inta_rise) normal_next = u8086_mode ? CTL_READY : ACK3;
            ACK3:    if (inta_rise) normal_next = CTL_READY;
            POLL:    if (read_rise) normal_next = CTL_READY;
            default: normal_next = CTL_READY;
        endcase
    end

    assign in_ack_state    = (state_reg == ACK1) | (state_reg == ACK2) | (state_reg == ACK3);
    assign timeout_expired = (TIMEOUT_CYCLES > 0) && (state_reg != CTL_READY) &&
                             (normal_next == state_reg) && (timeout_count_reg == TIMEOUT_LIMIT);

    always_comb begin
        state_next = normal_next;
        if (reset | write_initial_command_word_1 | timeout_expired) state_next = CTL_READY;
    end

    always_ff @(posedge clock) begin
        if (reset) state_reg <= CTL_READY;
        else       state_reg <= state_next;
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            always_ff @(posedge clock) begin
                if (reset || (state_reg == CTL_READY) || (state_next != state_reg))
                    timeout_count_reg <= '0;
                else if (timeout_count_reg != '1)
                    timeout_count_reg <= timeout_count_reg + 1'b1;
            end
        end else begin : g_no_timeout
            assign timeout_count_reg = '0;
        end
    endgenerate

    assign control_state      = state_reg;
    assign next_control_state = state_next;

    assign latch_in_service = ~(reset | write_initial_command_word_1 | timeout_expired) &
                              (((state_reg == ACK1) & inta_rise & slave_ok) |
                               ((state_reg == POLL) & read_fall));

    assign end_of_acknowledge_sequence = ~reset & ~write_initial_command_word_1 &
                              (((state_reg == ACK2) & inta_rise & u8086_mode) |
                               ((state_reg == ACK3) & inta_rise) |
                               (timeout_expired & in_ack_state));

    assign end_of_poll_command = ~reset & ~write_initial_command_word_1 &
                              (state_reg == POLL) & (read_rise | timeout_expired);

    assign sequence_abort = ~reset & ~write_initial_command_word_1 & timeout_expired;

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Scoreboard bench: scenarios queue expected state changes and strobes,
// a per-cycle sampler queues what the DUT actually produced.
module tb_interrupt_acknowledge_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic inta_n = 1'b1, read_n = 1'b1;
    logic icw1 = 1'b0, ocw3 = 1'b0, poll_bit = 1'b0;
    logic u8086 = 1'b1, cslave = 1'b0, csen = 1'b0;

    logic [2:0] cs0, ncs0, cs8, ncs8;
    logic lis0, eoa0, eop0, ab0, lis8, eoa8, eop8, ab8;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int obs_q[$];
    logic [2:0] prev_state = 3'b000;

    always #5 clock = ~clock;

    interrupt_acknowledge_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(16)) dut0 (
        .clock(clock), .reset(reset), .interrupt_acknowledge_n(inta_n), .read_n(read_n),
        .write_initial_command_word_1(icw1), .write_operation_control_word_3(ocw3),
        .poll_bit(poll_bit), .u8086_mode(u8086), .cascade_slave(cslave),
        .cascade_slave_enable(csen), .control_state(cs0), .next_control_state(ncs0),
        .latch_in_service(lis0), .end_of_acknowledge_sequence(eoa0),
        .end_of_poll_command(eop0), .sequence_abort(ab0));

    interrupt_acknowledge_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(16)) dut8 (
        .clock(clock), .reset(reset), .interrupt_acknowledge_n(inta_n), .read_n(read_n),
        .write_initial_command_word_1(icw1), .write_operation_control_word_3(ocw3),
        .poll_bit(poll_bit), .u8086_mode(u8086), .cascade_slave(cslave),
        .cascade_slave_enable(csen), .control_state(cs8), .next_control_state(ncs8),
        .latch_in_service(lis8), .end_of_acknowledge_sequence(eoa8),
        .end_of_poll_command(eop8), .sequence_abort(ab8));

    // Event codes: 100+state on a state change, 1 lis, 2 eoa, 3 eop, 4 abort.
    task automatic tick();
        @(posedge clock);
        #1;
        if (cs0 != prev_state) obs_q.push_back(100 + int'(cs0));
        if (lis0) obs_q.push_back(1);
        if (eoa0) obs_q.push_back(2);
        if (eop0) obs_q.push_back(3);
        if (ab0)  obs_q.push_back(4);
        prev_state = cs0;
    endtask

    task automatic compare_q(input string name);
        int e, o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s: missing event, got none, required %0d", name, e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s: event got %0d required %0d", name, o, e);
                end else
                    $display("ok   %s: event %0d", name, o);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d extra events, first got %0d required none", name, obs_q.size(), obs_q[0]);
        end
        obs_q.delete();
    endtask

    task automatic inta_pulse();
        inta_n = 1'b0;
        repeat (4) tick();
        inta_n = 1'b1;
        repeat (6) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({cs0, ncs0, lis0, eoa0, eop0, ab0} !== 10'b0 || {cs8, ncs8, lis8, eoa8, eop8, ab8} !== 10'b0) begin
            errors++;
            $display("FAIL reset: dut0 %b dut8 %b required all zero",
                     {cs0, ncs0, lis0, eoa0, eop0, ab0}, {cs8, ncs8, lis8, eoa8, eop8, ab8});
        end else
            $display("ok   reset: outputs zero");
        reset = 1'b0;
        repeat (4) tick();
        obs_q.delete();
    endtask

    task automatic test_8086();
        int lat;
        u8086 = 1'b1;
        exp_q = '{101, 1, 102, 2, 100};
        inta_n = 1'b0;
        repeat (4) tick();
        inta_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (lis0 && lat == 0) lat = k;
        end
        // Pin driven in period 1; strobe must be live in period 3.
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL lis_latency: got %0d ticks required 2", lat);
        end else
            $display("ok   lis_latency: %0d ticks", lat);
        inta_pulse();
        compare_q("8086");
    endtask

    task automatic test_8080();
        u8086 = 1'b0;
        exp_q = '{101, 1, 102, 103, 2, 100};
        repeat (3) inta_pulse();
        compare_q("8080");
        u8086 = 1'b1;
    endtask

    task automatic test_poll();
        exp_q = '{104, 1, 3, 100};
        ocw3 = 1'b1;
        poll_bit = 1'b1;
        tick();
        ocw3 = 1'b0;
        poll_bit = 1'b0;
        checks++;
        if (cs0 !== 3'b100) begin
            errors++;
            $display("FAIL poll_entry: state %b required 100", cs0);
        end else
            $display("ok   poll_entry: state %b", cs0);
        read_n = 1'b0;
        repeat (3) tick();
        read_n = 1'b1;
        repeat (6) tick();
        compare_q("poll");
    endtask

    task automatic test_cascade();
        cslave = 1'b1;
        csen = 1'b0;
        exp_q = '{101, 102, 2, 100};
        repeat (2) inta_pulse();
        compare_q("cascade_off");
        csen = 1'b1;
        exp_q = '{101, 1, 102, 2, 100};
        repeat (2) inta_pulse();
        compare_q("cascade_on");
        cslave = 1'b0;
        csen = 1'b0;
    endtask

    task automatic test_icw1_abort();
        exp_q = '{101, 1, 102, 100};
        inta_pulse();
        icw1 = 1'b1;
        #1;
        checks++;
        if (cs0 !== 3'b010 || ncs0 !== 3'b000 || lis0 !== 1'b0 || eoa0 !== 1'b0) begin
            errors++;
            $display("FAIL icw1: state %b next %b lis %b eoa %b required 010 000 0 0", cs0, ncs0, lis0, eoa0);
        end else
            $display("ok   icw1: next %b", ncs0);
        tick();
        icw1 = 1'b0;
        repeat (3) tick();
        compare_q("icw1");
    endtask

    task automatic test_reset_mid();
        exp_q = '{101, 100};
        inta_n = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        inta_n = 1'b1;
        tick();
        reset = 1'b0;
        repeat (6) tick();
        compare_q("reset_mid");
    endtask

    task automatic test_timeout();
        int n, n_at_abort, aborts;
        logic eoa_with;
        do_reset();
        exp_q = '{101, 1, 102};
        inta_n = 1'b0;
        repeat (4) tick();
        inta_n = 1'b1;
        n = 0;
        n_at_abort = -1;
        aborts = 0;
        eoa_with = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cs8 == 3'b010) n++;
            if (ab8) begin
                aborts++;
                if (n_at_abort < 0) begin
                    n_at_abort = n;
                    eoa_with = eoa8;
                end
            end
        end
        checks++;
        if (n_at_abort !== 8 || aborts !== 1) begin
            errors++;
            $display("FAIL timeout_cycles: abort after %0d ACK2 cycles (%0d aborts) required 8 (1)", n_at_abort, aborts);
        end else
            $display("ok   timeout_cycles: %0d", n_at_abort);
        checks++;
        if (eoa_with !== 1'b1) begin
            errors++;
            $display("FAIL timeout_eoa: got %b required 1", eoa_with);
        end else
            $display("ok   timeout_eoa");
        checks++;
        if (cs8 !== 3'b000) begin
            errors++;
            $display("FAIL timeout_state: got %b required 000", cs8);
        end else
            $display("ok   timeout_state: %b", cs8);
        repeat (10) tick();
        checks++;
        if (cs0 !== 3'b010) begin
            errors++;
            $display("FAIL no_timeout_hold: got %b required 010", cs0);
        end else
            $display("ok   no_timeout_hold: %b", cs0);
        compare_q("timeout_off");
        icw1 = 1'b1;
        tick();
        icw1 = 1'b0;
        tick();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_8086();
        test_8080();
        test_poll();
        test_cascade();
        test_icw1_abort();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
